// File: rtl/bus_map_pkg.sv
// Shared data-bus map for the single-cycle MIPS core: timer window base,
// register offsets, TCON bit positions and the decoder PCSrc code for IRQ.
// Also provides the timer register select type and its address decoder.
package bus_map_pkg;

  localparam logic [31:0] TIMER_BASE = 32'h4000_0000;
  localparam logic [31:0] TH_OFS     = 32'h0000_0000;
  localparam logic [31:0] TL_OFS     = 32'h0000_0004;
  localparam logic [31:0] TCON_OFS   = 32'h0000_0008;

  localparam int TCON_EN      = 0;
  localparam int TCON_IE      = 1;
  localparam int TCON_STATUS  = 2;
  localparam int TCON_ONESHOT = 3;

  // Decoder PCSrc value that vectors the core to the IRQ handler.
  localparam logic [2:0] PCSRC_IRQ = 3'b100;

  typedef enum logic [1:0] {
    SEL_TH   = 2'd0,
    SEL_TL   = 2'd1,
    SEL_TCON = 2'd2,
    SEL_NONE = 2'd3
  } tmr_sel_e;

  // Exact-match decode: any misaligned or out-of-window address is SEL_NONE.
  function automatic tmr_sel_e decode_sel(input logic [31:0] addr,
                                          input logic [31:0] base);
    logic [31:0] ofs;
    ofs = addr - base;
    if (ofs == TH_OFS)        return SEL_TH;
    else if (ofs == TL_OFS)   return SEL_TL;
    else if (ofs == TCON_OFS) return SEL_TCON;
    else                      return SEL_NONE;
  endfunction

endpackage

// File: rtl/timer_irq_ctrl_tick_prescaler.sv
// tick_prescaler: divides the enabled clock by PRESCALE.
// Ports:
//   clk   in  system clock
//   reset in  synchronous, active-high
//   en    in  timer enable; counter held at 0 while low
//   tick  out one-cycle pulse every PRESCALE enabled cycles
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  // PRESCALE = 1 leaves a 1-bit counter that never leaves 0, so tick = en.
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(PRESCALE - 1));
  assign tick   = en & w_wrap;

  always_ff @(posedge clk) begin
    if (reset)       r_cnt <= '0;
    else if (!en)    r_cnt <= '0;
    else if (w_wrap) r_cnt <= '0;
    else             r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: memory-mapped interval timer and IRQ source for the
// single-cycle MIPS core. TH = reload, TL = counter, TCON = {oneshot,status,ie,en}.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   pc_kernel         PC[31]; masks irq while the core is in kernel mode
//   addr, wdata       data bus byte address and store data
//   MemWr, MemRd      store / load strobes
//   rdata             same-cycle load data (0 unless MemRd & hit)
//   hit               addr is TH, TL or TCON exactly
//   irq               level interrupt request to the decoder
module timer_irq_ctrl
  import bus_map_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = TIMER_BASE,
  parameter int          PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_kernel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        MemWr,
  input  logic        MemRd,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic        r_en;
  logic        r_ie;
  logic        r_status;
  logic        r_oneshot;

  tmr_sel_e    w_sel;
  logic        w_tick;
  logic        w_ovf;
  logic        w_wr_th;
  logic        w_wr_tl;
  logic        w_wr_tcon;
  logic [31:0] w_tcon;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (r_en),
    .tick  (w_tick)
  );

  assign w_sel     = decode_sel(addr, BASE_ADDR);
  assign hit       = (w_sel != SEL_NONE);
  assign w_wr_th   = MemWr & (w_sel == SEL_TH);
  assign w_wr_tl   = MemWr & (w_sel == SEL_TL);
  assign w_wr_tcon = MemWr & (w_sel == SEL_TCON);
  assign w_ovf     = w_tick & (r_tl == 32'hFFFF_FFFF);
  assign w_tcon    = {28'd0, r_oneshot, r_status, r_ie, r_en};

  // Kernel mode masks the request so the handler is never re-entered.
  assign irq = r_ie & r_status & ~pc_kernel;

  always_comb begin
    rdata = 32'd0;
    if (MemRd) begin
      case (w_sel)
        SEL_TH:   rdata = r_th;
        SEL_TL:   rdata = r_tl;
        SEL_TCON: rdata = w_tcon;
        default:  rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_th      <= 32'd0;
      r_tl      <= 32'd0;
      r_en      <= 1'b0;
      r_ie      <= 1'b0;
      r_status  <= 1'b0;
      r_oneshot <= 1'b0;
    end else begin
      if (w_wr_th) r_th <= wdata;

      // A software write to TL beats both increment and reload.
      if (w_wr_tl)     r_tl <= wdata;
      else if (w_tick) r_tl <= w_ovf ? r_th : r_tl + 32'd1;

      // Written en beats the oneshot self-disable.
      if (w_wr_tcon) begin
        r_en      <= wdata[TCON_EN];
        r_ie      <= wdata[TCON_IE];
        r_oneshot <= wdata[TCON_ONESHOT];
      end else if (w_ovf & r_oneshot) begin
        r_en      <= 1'b0;
      end

      // Write-0-to-clear; a coincident overflow keeps status set.
      if (w_ovf)                                  r_status <= 1'b1;
      else if (w_wr_tcon & ~wdata[TCON_STATUS])   r_status <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
module tb_timer_irq_ctrl;

  localparam logic [31:0] B = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_kernel = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        MemWr = 1'b0;
  logic        MemRd = 1'b0;
  logic [31:0] rdata_a, rdata_b;
  logic        hit_a, hit_b, irq_a, irq_b;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  timer_irq_ctrl #(.BASE_ADDR(B), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(reset), .pc_kernel(pc_kernel), .addr(addr), .wdata(wdata),
    .MemWr(MemWr), .MemRd(MemRd), .rdata(rdata_a), .hit(hit_a), .irq(irq_a));

  timer_irq_ctrl #(.BASE_ADDR(B), .PRESCALE(4)) dut_b (
    .clk(clk), .reset(reset), .pc_kernel(pc_kernel), .addr(addr), .wdata(wdata),
    .MemWr(MemWr), .MemRd(MemRd), .rdata(rdata_b), .hit(hit_b), .irq(irq_b));

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] th;
    logic [31:0] tl;
    bit          en, ie, st, os;
    int          phase;  // enabled cycles since the last tick
  } ms_t;

  ms_t m[2];

  function automatic int regidx(input logic [31:0] a);
    if (a == B)          return 0;
    else if (a == B + 4) return 1;
    else if (a == B + 8) return 2;
    else                 return -1;
  endfunction

  function automatic logic [31:0] mreg(input ms_t s, input int idx);
    case (idx)
      0:       return s.th;
      1:       return s.tl;
      2:       return {28'd0, s.os, s.st, s.ie, s.en};
      default: return 32'd0;
    endcase
  endfunction

  function automatic ms_t mstep(input ms_t s, input int pre);
    ms_t n;
    bit  tick, ovf;
    int  r;
    if (reset) begin
      n.th = 0; n.tl = 0; n.en = 0; n.ie = 0; n.st = 0; n.os = 0; n.phase = 0;
      return n;
    end
    n    = s;
    tick = s.en && (s.phase == pre - 1);
    ovf  = tick && (s.tl == 32'hFFFF_FFFF);
    n.phase = (s.en && !tick) ? s.phase + 1 : 0;
    if (tick) n.tl = ovf ? s.th : s.tl + 1;
    if (ovf) begin
      n.st = 1;
      if (s.os) n.en = 0;
    end
    r = regidx(addr);
    if (MemWr && r == 0) n.th = wdata;
    if (MemWr && r == 1) n.tl = wdata;
    if (MemWr && r == 2) begin
      n.en = wdata[0];
      n.ie = wdata[1];
      n.os = wdata[3];
      n.st = ovf || (s.st && wdata[2]);
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m[0] <= mstep(m[0], 1);
    m[1] <= mstep(m[1], 4);
  end

  task automatic cmp(input int i, input logic [31:0] rd, input logic h, input logic q);
    logic [31:0] erd;
    logic        eh, eq;
    int          r;
    r   = regidx(addr);
    eh  = (r >= 0);
    erd = (MemRd && eh) ? mreg(m[i], r) : 32'd0;
    eq  = m[i].ie && m[i].st && !pc_kernel;
    checks++;
    if (rd !== erd || h !== eh || q !== eq) begin
      errors++;
      $display("FAIL model_cmp dut%0d t=%0t: rdata=%h hit=%b irq=%b, required rdata=%h hit=%b irq=%b",
               i, $time, rd, h, q, erd, eh, eq);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, rdata_a, hit_a, irq_a);
      cmp(1, rdata_b, hit_b, irq_b);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; MemWr = 1'b1; MemRd = 1'b0;
    cyc();
    MemWr = 1'b0;
  endtask

  // At most three reads per cycle so the bus is stable at the negedge compare.
  task automatic rd(input bit use_b, input logic [31:0] a, input logic [31:0] exp, input string nm);
    addr = a; MemRd = 1'b1; MemWr = 1'b0;
    #1;
    chk(nm, use_b ? rdata_b : rdata_a, exp);
  endtask

  initial begin
    reset = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc();
    reset = 1'b0;
    rd(0, B,     32'd0, "reset_th");
    rd(0, B + 4, 32'd0, "reset_tl");
    rd(0, B + 8, 32'd0, "reset_tcon");
    chk("reset_irq", {31'd0, irq_a}, 32'd0);

    // 1: count to overflow and reload
    wr(B,     32'hFFFF_FFFC);
    wr(B + 4, 32'hFFFF_FFFE);
    wr(B + 8, 32'h3);
    rd(0, B + 4, 32'hFFFF_FFFE, "t1_tl_start");
    cyc();
    rd(0, B + 4, 32'hFFFF_FFFF, "t1_tl_1clk");
    chk("t1_irq_pre", {31'd0, irq_a}, 32'd0);
    cyc();
    rd(0, B + 4, 32'hFFFF_FFFC, "t1_tl_reload");
    rd(0, B + 8, 32'h7,         "t1_tcon_status");
    chk("t1_irq", {31'd0, irq_a}, 32'd1);

    // 2: kernel-mode masking and status clear
    cyc();
    pc_kernel = 1'b1; #1;
    chk("t2_irq_kernel", {31'd0, irq_a}, 32'd0);
    pc_kernel = 1'b0; #1;
    chk("t2_irq_user_again", {31'd0, irq_a}, 32'd1);
    pc_kernel = 1'b1;
    wr(B + 8, 32'h3);
    pc_kernel = 1'b0; #1;
    chk("t2_irq_cleared", {31'd0, irq_a}, 32'd0);
    rd(0, B + 8, 32'h3, "t2_tcon");
    wr(B + 8, 32'h0);

    // 3: prescaler on the PRESCALE=4 instance
    wr(B + 4, 32'd0);
    wr(B + 8, 32'h1);
    rd(1, B + 4, 32'd0, "t3_tl0");
    repeat (3) cyc();
    rd(1, B + 4, 32'd0, "t3_tl_3clk");
    cyc();
    rd(1, B + 4, 32'd1, "t3_tl_4clk");
    repeat (3) cyc();
    rd(1, B + 4, 32'd1, "t3_tl_7clk");
    cyc();
    rd(1, B + 4, 32'd2, "t3_tl_8clk");
    repeat (2) cyc();
    wr(B + 8, 32'h0);
    repeat (5) cyc();
    rd(1, B + 4, 32'd2, "t3_tl_frozen");
    wr(B + 8, 32'h1);
    repeat (3) cyc();
    rd(1, B + 4, 32'd2, "t3_restart_3clk");
    cyc();
    rd(1, B + 4, 32'd3, "t3_restart_4clk");

    // 4: oneshot
    wr(B + 8, 32'h0);
    wr(B,     32'd5);
    wr(B + 4, 32'hFFFF_FFFF);
    wr(B + 8, 32'h9);
    rd(0, B + 4, 32'hFFFF_FFFF, "t4_tl_pre");
    cyc();
    rd(0, B + 4, 32'd5,  "t4_tl_reload");
    rd(0, B + 8, 32'hC,  "t4_tcon");
    chk("t4_irq_ie0", {31'd0, irq_a}, 32'd0);
    repeat (10) cyc();
    rd(0, B + 4, 32'd5, "t4_tl_hold");

    // 5: simultaneous events
    wr(B + 8, 32'h0);
    wr(B,     32'd7);
    wr(B + 4, 32'hFFFF_FFFE);
    wr(B + 8, 32'h3);
    cyc();
    wr(B + 4, 32'h100);
    rd(0, B + 4, 32'h100, "t5_tl_write_wins");
    rd(0, B + 8, 32'h7,   "t5_status_set");
    chk("t5_irq", {31'd0, irq_a}, 32'd1);
    wr(B + 8, 32'h3);
    rd(0, B + 8, 32'h3, "t5_status_cleared");
    wr(B + 4, 32'hFFFF_FFFF);
    wr(B + 8, 32'h3);
    rd(0, B + 4, 32'd7, "t5_tl_reload");
    rd(0, B + 8, 32'h7, "t5_set_beats_clear");
    chk("t5_irq2", {31'd0, irq_a}, 32'd1);
    wr(B + 8, 32'h9);
    wr(B + 4, 32'hFFFF_FFFF);
    wr(B + 8, 32'h9);
    rd(0, B + 8, 32'hD, "t5_written_en_wins");
    rd(0, B + 4, 32'd7, "t5_tl_reload2");

    // 6: reset mid-count, then bad addresses
    wr(B + 8, 32'h7);
    chk("t6_irq_pre", {31'd0, irq_a}, 32'd1);
    reset = 1'b1;
    cyc();
    rd(0, B,     32'd0, "t6_th");
    rd(0, B + 4, 32'd0, "t6_tl");
    rd(0, B + 8, 32'd0, "t6_tcon");
    chk("t6_irq", {31'd0, irq_a}, 32'd0);
    reset = 1'b0;
    cyc();
    rd(0, B + 32'hC, 32'd0, "t6_rd_oow");
    chk("t6_hit_oow", {31'd0, hit_a}, 32'd0);
    rd(0, B + 2, 32'd0, "t6_rd_misaligned");
    chk("t6_hit_misaligned", {31'd0, hit_a}, 32'd0);
    wr(B + 32'hC, 32'hFFFF_FFFF);
    wr(B + 2,     32'hFFFF_FFFF);
    wr(B + 1,     32'hFFFF_FFFF);
    wr(B - 4,     32'hFFFF_FFFF);
    rd(0, B,     32'd0, "t6_th_untouched");
    rd(0, B + 4, 32'd0, "t6_tl_untouched");
    rd(0, B + 8, 32'd0, "t6_tcon_untouched");
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
